// File: rtl/mem_bus_pkg.sv
// Shared definitions for the SDRAM request-port arbiter: bus widths and
// the arbiter FSM state encoding.
package mem_bus_pkg;

  localparam int DATA_W  = 32;
  localparam int WSTRB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY0 = 2'd1,
    ST_BUSY1 = 2'd2
  } state_t;

  function automatic logic [1:0] port_onehot(input logic port);
    return port ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/arb_wait_counter.sv
// Per-port saturating wait counter: counts cycles a valid request is left
// waiting, freezes while the port is being served, clears on selection or idle.
module arb_wait_counter #(
  parameter int MAX_WAIT = 16,
  parameter int WAIT_W   = $clog2(MAX_WAIT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic i_valid,
  input  logic i_hold,
  input  logic i_clear,
  output logic o_saturated
);

  logic [WAIT_W-1:0] count_q, count_d;
  logic              at_max;

  assign at_max      = (count_q == WAIT_W'(MAX_WAIT));
  assign o_saturated = i_valid && at_max;

  always_comb begin
    count_d = count_q;
    if (!i_valid || i_clear) begin
      count_d = '0;
    end else if (!i_hold && !at_max) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Two-port arbiter in front of the single SDRAM controller request port.
// Priority: starvation override, then p0 urgent, then round-robin.
module sdram_port_arbiter
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 16,
  parameter int WAIT_W   = $clog2(MAX_WAIT + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_p0_valid,
  input  logic               i_p0_urgent,
  input  logic [ADDR_W-1:0]  i_p0_addr,
  input  logic [DATA_W-1:0]  i_p0_wdata,
  input  logic [WSTRB_W-1:0] i_p0_wstrb,
  output logic               o_p0_ready,
  output logic [DATA_W-1:0]  o_p0_rdata,
  input  logic               i_p1_valid,
  input  logic [ADDR_W-1:0]  i_p1_addr,
  input  logic [DATA_W-1:0]  i_p1_wdata,
  input  logic [WSTRB_W-1:0] i_p1_wstrb,
  output logic               o_p1_ready,
  output logic [DATA_W-1:0]  o_p1_rdata,
  output logic               o_mem_valid,
  output logic [ADDR_W-1:0]  o_mem_addr,
  output logic [DATA_W-1:0]  o_mem_wdata,
  output logic [WSTRB_W-1:0] o_mem_wstrb,
  input  logic               i_mem_ready,
  input  logic [DATA_W-1:0]  i_mem_rdata,
  output logic [1:0]         o_grant
);

  state_t               state_q, state_d;
  logic                 mem_valid_q, mem_valid_d;
  logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]    mem_wdata_q, mem_wdata_d;
  logic [WSTRB_W-1:0]   mem_wstrb_q, mem_wstrb_d;
  logic [1:0]           grant_q, grant_d;
  // Port favoured on a round-robin tie: the one not served last (p0 out of reset).
  logic                 favour_q, favour_d;

  logic [1:0] req_v, busy_v, sel_v, sat_v;
  logic       win_any, win_p1;

  assign req_v  = {i_p1_valid, i_p0_valid};
  assign busy_v = {state_q == ST_BUSY1, state_q == ST_BUSY0};

  for (genvar gi = 0; gi < 2; gi++) begin : g_wait
    arb_wait_counter #(
      .MAX_WAIT (MAX_WAIT),
      .WAIT_W   (WAIT_W)
    ) u_wait (
      .clk         (clk),
      .rst         (rst),
      .i_valid     (req_v[gi]),
      .i_hold      (busy_v[gi]),
      .i_clear     (sel_v[gi]),
      .o_saturated (sat_v[gi])
    );
  end

  always_comb begin
    win_any = 1'b0;
    win_p1  = 1'b0;
    if (state_q == ST_IDLE) begin
      if (&sat_v) begin
        win_any = 1'b1;
        win_p1  = favour_q;
      end else if (sat_v[0]) begin
        win_any = 1'b1;
      end else if (sat_v[1]) begin
        win_any = 1'b1;
        win_p1  = 1'b1;
      end else if (i_p0_valid && i_p0_urgent) begin
        win_any = 1'b1;
      end else if (&req_v) begin
        win_any = 1'b1;
        win_p1  = favour_q;
      end else if (|req_v) begin
        win_any = 1'b1;
        win_p1  = req_v[1];
      end
    end
    sel_v = win_any ? port_onehot(win_p1) : 2'b00;
  end

  always_comb begin
    state_d     = state_q;
    mem_valid_d = mem_valid_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    grant_d     = grant_q;
    favour_d    = favour_q;
    case (state_q)
      ST_IDLE: begin
        if (win_any) begin
          state_d     = win_p1 ? ST_BUSY1 : ST_BUSY0;
          mem_valid_d = 1'b1;
          grant_d     = sel_v;
          mem_addr_d  = win_p1 ? i_p1_addr  : i_p0_addr;
          mem_wdata_d = win_p1 ? i_p1_wdata : i_p0_wdata;
          mem_wstrb_d = win_p1 ? i_p1_wstrb : i_p0_wstrb;
        end
      end
      ST_BUSY0, ST_BUSY1: begin
        if (i_mem_ready) begin
          state_d     = ST_IDLE;
          mem_valid_d = 1'b0;
          grant_d     = 2'b00;
          favour_d    = (state_q == ST_BUSY0);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      grant_q     <= 2'b00;
      favour_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      grant_q     <= grant_d;
      favour_q    <= favour_d;
    end
  end

  // Completion is steered only to the port that owns the current transaction.
  assign o_p0_ready  = busy_v[0] && i_mem_ready;
  assign o_p1_ready  = busy_v[1] && i_mem_ready;
  assign o_p0_rdata  = o_p0_ready ? i_mem_rdata : '0;
  assign o_p1_rdata  = o_p1_ready ? i_mem_rdata : '0;

  assign o_mem_valid = mem_valid_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_mem_wstrb = mem_wstrb_q;
  assign o_grant     = grant_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter with MAX_WAIT=4; a scripted controller
// model answers each granted request after a chosen number of cycles.
module tb_sdram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_p0_valid, i_p0_urgent, i_p1_valid;
  logic [31:0] i_p0_addr, i_p0_wdata, i_p1_addr, i_p1_wdata;
  logic [3:0]  i_p0_wstrb, i_p1_wstrb;
  logic        o_p0_ready, o_p1_ready;
  logic [31:0] o_p0_rdata, o_p1_rdata;
  logic        o_mem_valid;
  logic [31:0] o_mem_addr, o_mem_wdata;
  logic [3:0]  o_mem_wstrb;
  logic        i_mem_ready;
  logic [31:0] i_mem_rdata;
  logic [1:0]  o_grant;

  int errors = 0;
  int checks = 0;

  sdram_port_arbiter #(.ADDR_W(32), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .i_p0_valid(i_p0_valid), .i_p0_urgent(i_p0_urgent), .i_p0_addr(i_p0_addr),
    .i_p0_wdata(i_p0_wdata), .i_p0_wstrb(i_p0_wstrb),
    .o_p0_ready(o_p0_ready), .o_p0_rdata(o_p0_rdata),
    .i_p1_valid(i_p1_valid), .i_p1_addr(i_p1_addr),
    .i_p1_wdata(i_p1_wdata), .i_p1_wstrb(i_p1_wstrb),
    .o_p1_ready(o_p1_ready), .o_p1_rdata(o_p1_rdata),
    .o_mem_valid(o_mem_valid), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_wstrb(o_mem_wstrb),
    .i_mem_ready(i_mem_ready), .i_mem_rdata(i_mem_rdata),
    .o_grant(o_grant)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Requesters must hold valid while granted.
  always @(negedge clk) begin
    #2;
    if (!rst && ((o_grant[0] && !i_p0_valid) || (o_grant[1] && !i_p1_valid))) begin
      errors++;
      $error("FAIL protocol: valid dropped while granted, grant=%b", o_grant);
    end
  end

  // Wait for a grant, check the granted fields every cycle, answer after lat cycles.
  task automatic serve(input string tag, input logic [1:0] g, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] ws, input int lat,
                       input logic [31:0] rd, input int exp_wait);
    int  waited = 0;
    bit  seen   = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      waited++;
      if (o_mem_valid) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, ".seen"}, 64'(seen), 64'd1);
    if (!seen) return;
    if (exp_wait > 0) chk({tag, ".latency"}, 64'(waited), 64'(exp_wait));
    chk({tag, ".grant_addr"}, {30'd0, o_grant, o_mem_addr}, {30'd0, g, a});
    chk({tag, ".wdata_wstrb"}, {28'd0, o_mem_wstrb, o_mem_wdata}, {28'd0, ws, wd});
    for (int c = 0; c < lat; c++) begin
      @(negedge clk);
      chk({tag, ".hold"}, {29'd0, o_mem_valid, o_grant, o_mem_addr}, {29'd0, 1'b1, g, a});
      chk({tag, ".hold_wd"}, {28'd0, o_mem_wstrb, o_mem_wdata}, {28'd0, ws, wd});
      chk({tag, ".no_early_ready"}, {62'd0, o_p1_ready, o_p0_ready}, 64'd0);
    end
    i_mem_ready = 1'b1;
    i_mem_rdata = rd;
    #1;
    chk({tag, ".ready"}, {62'd0, o_p1_ready, o_p0_ready}, {62'd0, g});
    chk({tag, ".rdata"}, g[1] ? {o_p0_rdata, o_p1_rdata} : {o_p1_rdata, o_p0_rdata},
        {32'd0, rd});
    @(negedge clk);
    i_mem_ready = 1'b0;
    i_mem_rdata = '0;
    chk({tag, ".release"}, {61'd0, o_mem_valid, o_grant}, 64'd0);
    $display("txn %s grant=%b addr=%h wstrb=%h rdata=%h wait=%0d lat=%0d",
             tag, g, a, ws, rd, waited, lat);
  endtask

  initial begin
    rst = 1'b1;
    i_p0_valid = 0; i_p0_urgent = 0; i_p0_addr = '0; i_p0_wdata = '0; i_p0_wstrb = '0;
    i_p1_valid = 0; i_p1_addr = '0; i_p1_wdata = '0; i_p1_wstrb = '0;
    i_mem_ready = 0; i_mem_rdata = '0;
    repeat (2) @(negedge clk);
    chk("reset.mem", {29'd0, o_mem_valid, o_grant, o_mem_addr}, 64'd0);
    chk("reset.ready", {o_p1_ready, o_p0_ready, o_p1_rdata | o_p0_rdata}, 64'd0);
    rst = 1'b0;

    // Lone p1 read, controller answers 3 cycles after o_mem_valid.
    i_p1_valid = 1; i_p1_addr = 32'h0000_0100; i_p1_wstrb = 4'h0; i_p1_wdata = 32'h0;
    serve("p1_read", 2'b10, 32'h100, 32'h0, 4'h0, 3, 32'hDEAD_BEEF, 1);
    i_p1_valid = 0;

    // Both valid, no urgent: strict alternation, one bubble per transaction.
    i_p0_valid = 1; i_p0_addr = 32'h200; i_p0_wdata = 32'hA0A0_A0A0; i_p0_wstrb = 4'hF;
    i_p1_valid = 1; i_p1_addr = 32'h300; i_p1_wdata = 32'hB1B1_B1B1; i_p1_wstrb = 4'h1;
    serve("rr0", 2'b01, 32'h200, 32'hA0A0_A0A0, 4'hF, 1, 32'h1111_0000, 1);
    serve("rr1", 2'b10, 32'h300, 32'hB1B1_B1B1, 4'h1, 1, 32'h2222_0000, 1);
    serve("rr2", 2'b01, 32'h200, 32'hA0A0_A0A0, 4'hF, 1, 32'h3333_0000, 1);
    serve("rr3", 2'b10, 32'h300, 32'hB1B1_B1B1, 4'h1, 1, 32'h4444_0000, 1);
    i_p0_valid = 0; i_p1_valid = 0;
    @(negedge clk);

    // p0 urgent: p1 gains 3 per p0 transaction, saturates at 4 after the second.
    i_p0_valid = 1; i_p0_urgent = 1; i_p1_valid = 1;
    serve("urg0", 2'b01, 32'h200, 32'hA0A0_A0A0, 4'hF, 1, 32'h5, 1);
    serve("urg1", 2'b01, 32'h200, 32'hA0A0_A0A0, 4'hF, 1, 32'h6, 1);
    serve("starve", 2'b10, 32'h300, 32'hB1B1_B1B1, 4'h1, 1, 32'h7, 1);
    serve("urg2", 2'b01, 32'h200, 32'hA0A0_A0A0, 4'hF, 1, 32'h8, 1);
    serve("urg3", 2'b01, 32'h200, 32'hA0A0_A0A0, 4'hF, 1, 32'h9, 1);
    i_p0_valid = 0; i_p0_urgent = 0; i_p1_valid = 0;
    @(negedge clk);

    // p1 write with a 20-cycle controller stall.
    i_p1_valid = 1; i_p1_addr = 32'h0000_0440; i_p1_wdata = 32'h1234_5678; i_p1_wstrb = 4'h3;
    serve("stall", 2'b10, 32'h440, 32'h1234_5678, 4'h3, 20, 32'h0, 1);
    i_p1_valid = 0;
    @(negedge clk);

    // Reset two cycles into a BUSY0 transaction.
    i_p0_valid = 1; i_p0_addr = 32'h800;
    @(negedge clk);
    chk("rst.busy0", {62'd0, o_grant}, 64'd1);
    @(negedge clk);
    rst = 1; i_p0_valid = 0;
    @(negedge clk);
    chk("rst.cleared", {29'd0, o_mem_valid, o_grant, o_mem_addr}, 64'd0);
    i_mem_ready = 1;
    #1;
    chk("rst.no_ready", {62'd0, o_p1_ready, o_p0_ready}, 64'd0);
    i_mem_ready = 0;
    rst = 0;
    $display("txn rst_mid_busy0 abandoned");
    i_p1_valid = 1; i_p1_addr = 32'h900; i_p1_wdata = 32'h0; i_p1_wstrb = 4'h0;
    serve("post_rst", 2'b10, 32'h900, 32'h0, 4'h0, 1, 32'hCAFE_F00D, 1);
    i_p1_valid = 0;
    @(negedge clk);

    // Spurious controller ready while idle.
    i_mem_ready = 1; i_mem_rdata = 32'h5A5A_5A5A;
    #1;
    chk("spur.ready", {o_p1_ready, o_p0_ready, o_p1_rdata | o_p0_rdata}, 64'd0);
    @(negedge clk);
    chk("spur.state", {61'd0, o_mem_valid, o_grant}, 64'd0);
    i_mem_ready = 0; i_mem_rdata = '0;
    @(negedge clk);
    chk("spur.after", {61'd0, o_mem_valid, o_grant}, 64'd0);
    $display("txn spurious_ready ignored");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
